// File: rtl/pong_pkg.sv
// Shared types and constants for the pong frame writer.
package pong_pkg;

  // Default screen geometry and object sizes.
  localparam int H_RES_DEFAULT   = 640;
  localparam int V_RES_DEFAULT   = 480;
  localparam int PAD_W_DEFAULT   = 8;
  localparam int PAD_H_DEFAULT   = 64;
  localparam int BALL_SZ_DEFAULT = 8;
  localparam int PAD_L_X_DEFAULT = 16;
  localparam int PAD_R_X_DEFAULT = 616;

  localparam int COORD_W = 10;

  // Dashed centre line: four pixels wide, dashes toggle every 16 lines.
  localparam int CENTRE_X_LO = 318;
  localparam int CENTRE_X_HI = 321;

  // Render sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    DRAW,
    WAIT_VB,
    SWAP
  } state_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  localparam rgb_t COLOR_BLACK = 24'h000000;
  localparam rgb_t COLOR_WHITE = 24'hFFFFFF;
  localparam rgb_t COLOR_GREY  = 24'h808080;

  // True when lo <= v < lo+len. The upper bound is formed in 11 bits so an
  // object sitting near coordinate 1023 clips at the edge rather than
  // wrapping around onto small coordinates.
  function automatic logic in_span(input logic [COORD_W-1:0] v,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W:0]   len);
    logic [COORD_W:0] hi;
    hi = {1'b0, lo} + len;
    return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < hi);
  endfunction

endpackage

// File: rtl/pong_pixel_shader.sv
// Combinational colour lookup for one screen pixel given the object positions.
module pong_pixel_shader
  import pong_pkg::*;
#(
  parameter int PAD_W   = PAD_W_DEFAULT,
  parameter int PAD_H   = PAD_H_DEFAULT,
  parameter int BALL_SZ = BALL_SZ_DEFAULT,
  parameter int PAD_L_X = PAD_L_X_DEFAULT,
  parameter int PAD_R_X = PAD_R_X_DEFAULT
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] ball_x_i,
  input  logic [COORD_W-1:0] ball_y_i,
  input  logic [COORD_W-1:0] paddle_l_y_i,
  input  logic [COORD_W-1:0] paddle_r_y_i,
  output rgb_t               rgb_o
);

  localparam logic [COORD_W-1:0] PAD_L_X_C  = COORD_W'(PAD_L_X);
  localparam logic [COORD_W-1:0] PAD_R_X_C  = COORD_W'(PAD_R_X);
  localparam logic [COORD_W:0]   PAD_W_C    = (COORD_W + 1)'(PAD_W);
  localparam logic [COORD_W:0]   PAD_H_C    = (COORD_W + 1)'(PAD_H);
  localparam logic [COORD_W:0]   BALL_SZ_C  = (COORD_W + 1)'(BALL_SZ);
  localparam logic [COORD_W-1:0] CENTRE_LO  = COORD_W'(CENTRE_X_LO);
  localparam logic [COORD_W-1:0] CENTRE_HI  = COORD_W'(CENTRE_X_HI);

  logic ball_hit;
  logic pad_l_hit;
  logic pad_r_hit;
  logic centre_hit;

  // Hit tests for each object at the current pixel.
  always_comb begin
    ball_hit   = in_span(x_i, ball_x_i, BALL_SZ_C) && in_span(y_i, ball_y_i, BALL_SZ_C);
    pad_l_hit  = in_span(x_i, PAD_L_X_C, PAD_W_C) && in_span(y_i, paddle_l_y_i, PAD_H_C);
    pad_r_hit  = in_span(x_i, PAD_R_X_C, PAD_W_C) && in_span(y_i, paddle_r_y_i, PAD_H_C);
    centre_hit = (x_i >= CENTRE_LO) && (x_i <= CENTRE_HI) && !y_i[4];
  end

  // Priority: ball, then paddles, then centre line, else background.
  always_comb begin
    rgb_o = COLOR_BLACK;
    if (ball_hit) begin
      rgb_o = COLOR_WHITE;
    end else if (pad_l_hit || pad_r_hit) begin
      rgb_o = COLOR_WHITE;
    end else if (centre_hit) begin
      rgb_o = COLOR_GREY;
    end
  end

endmodule

// File: rtl/pong_frame_writer.sv
// Renders one full pong frame into the back buffer per frame_start, then
// waits for vertical blank to swap buffers.
module pong_frame_writer
  import pong_pkg::*;
#(
  parameter int H_RES   = H_RES_DEFAULT,
  parameter int V_RES   = V_RES_DEFAULT,
  parameter int PAD_W   = PAD_W_DEFAULT,
  parameter int PAD_H   = PAD_H_DEFAULT,
  parameter int BALL_SZ = BALL_SZ_DEFAULT,
  parameter int PAD_L_X = PAD_L_X_DEFAULT,
  parameter int PAD_R_X = PAD_R_X_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                vblank_start,
  input  logic [COORD_W-1:0]  ball_x,
  input  logic [COORD_W-1:0]  ball_y,
  input  logic [COORD_W-1:0]  paddle_l_y,
  input  logic [COORD_W-1:0]  paddle_r_y,
  output logic [COORD_W-1:0]  oX,
  output logic [COORD_W-1:0]  oY,
  output logic [7:0]          oRed,
  output logic [7:0]          oGreen,
  output logic [7:0]          oBlue,
  output logic                write_enable,
  output logic                write_buffer_select,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  state_t state_q, state_d;

  // The output coordinate registers double as the raster counters.
  logic [COORD_W-1:0] ox_q, ox_d;
  logic [COORD_W-1:0] oy_q, oy_d;
  rgb_t               rgb_q, rgb_d;
  logic               we_q, we_d;
  logic               wbs_q, wbs_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;

  // Object positions frozen for the duration of one frame.
  logic [COORD_W-1:0] ball_x_q, ball_x_d;
  logic [COORD_W-1:0] ball_y_q, ball_y_d;
  logic [COORD_W-1:0] pad_l_y_q, pad_l_y_d;
  logic [COORD_W-1:0] pad_r_y_q, pad_r_y_d;

  logic               x_last;
  logic               frame_last;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;

  logic [COORD_W-1:0] shade_x;
  logic [COORD_W-1:0] shade_y;
  logic [COORD_W-1:0] shade_ball_x;
  logic [COORD_W-1:0] shade_ball_y;
  logic [COORD_W-1:0] shade_pad_l_y;
  logic [COORD_W-1:0] shade_pad_r_y;
  rgb_t               shade_rgb;

  // Raster stepping from the pixel currently on the outputs.
  assign x_last     = (ox_q == X_LAST);
  assign frame_last = x_last && (oy_q == Y_LAST);
  assign next_x     = x_last ? '0 : ox_q + 1'b1;
  assign next_y     = x_last ? oy_q + 1'b1 : oy_q;

  // In LATCH the positions are being captured this very cycle, so pixel
  // (0,0) is shaded from the live inputs; afterwards only latched copies.
  assign shade_x       = (state_q == DRAW) ? next_x : '0;
  assign shade_y       = (state_q == DRAW) ? next_y : '0;
  assign shade_ball_x  = (state_q == LATCH) ? ball_x     : ball_x_q;
  assign shade_ball_y  = (state_q == LATCH) ? ball_y     : ball_y_q;
  assign shade_pad_l_y = (state_q == LATCH) ? paddle_l_y : pad_l_y_q;
  assign shade_pad_r_y = (state_q == LATCH) ? paddle_r_y : pad_r_y_q;

  pong_pixel_shader #(
    .PAD_W   (PAD_W),
    .PAD_H   (PAD_H),
    .BALL_SZ (BALL_SZ),
    .PAD_L_X (PAD_L_X),
    .PAD_R_X (PAD_R_X)
  ) u_shader (
    .x_i          (shade_x),
    .y_i          (shade_y),
    .ball_x_i     (shade_ball_x),
    .ball_y_i     (shade_ball_y),
    .paddle_l_y_i (shade_pad_l_y),
    .paddle_r_y_i (shade_pad_r_y),
    .rgb_o        (shade_rgb)
  );

  // Next-state and next-output logic for the render sequencer.
  always_comb begin
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    rgb_d        = rgb_q;
    we_d         = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = frame_start && (state_q != IDLE);
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    pad_l_y_d    = pad_l_y_q;
    pad_r_y_d    = pad_r_y_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        ball_x_d  = ball_x;
        ball_y_d  = ball_y;
        pad_l_y_d = paddle_l_y;
        pad_r_y_d = paddle_r_y;
        we_d      = 1'b1;
        ox_d      = '0;
        oy_d      = '0;
        rgb_d     = shade_rgb;
        state_d   = DRAW;
      end
      DRAW: begin
        if (frame_last) begin
          state_d = WAIT_VB;
        end else begin
          we_d  = 1'b1;
          ox_d  = next_x;
          oy_d  = next_y;
          rgb_d = shade_rgb;
        end
      end
      WAIT_VB: begin
        if (vblank_start) begin
          frame_done_d = 1'b1;
          state_d      = SWAP;
        end
      end
      SWAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wbs_d  = wbs_q ^ frame_done_d;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset overrides every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ox_q         <= '0;
      oy_q         <= '0;
      rgb_q        <= COLOR_BLACK;
      we_q         <= 1'b0;
      wbs_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      pad_l_y_q    <= '0;
      pad_r_y_q    <= '0;
    end else begin
      state_q      <= state_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      rgb_q        <= rgb_d;
      we_q         <= we_d;
      wbs_q        <= wbs_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      pad_l_y_q    <= pad_l_y_d;
      pad_r_y_q    <= pad_r_y_d;
    end
  end

  assign oX                  = ox_q;
  assign oY                  = oy_q;
  assign oRed                = rgb_q.red;
  assign oGreen              = rgb_q.green;
  assign oBlue               = rgb_q.blue;
  assign write_enable        = we_q;
  assign write_buffer_select = wbs_q;
  assign busy                = busy_q;
  assign frame_done          = frame_done_q;
  assign overrun             = overrun_q;

endmodule

// File: tb/tb_pong_frame_writer.sv
// Directed bench for pong_frame_writer on a reduced 328x24 screen.
module tb_pong_frame_writer;

  localparam int H    = 328;
  localparam int V    = 24;
  localparam int PR_X = 300;
  localparam int NPIX = H * V;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       vblank_start;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [9:0] oX, oY;
  logic [7:0] oRed, oGreen, oBlue;
  logic       write_enable, write_buffer_select, busy, frame_done, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int nwr, order_err, busy_err, ovr_hits;
  logic [23:0] fb [0:NPIX-1];

  always #5 clk = ~clk;

  pong_frame_writer #(
    .H_RES   (H),
    .V_RES   (V),
    .PAD_W   (8),
    .PAD_H   (64),
    .BALL_SZ (8),
    .PAD_L_X (16),
    .PAD_R_X (PR_X)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .frame_start         (frame_start),
    .vblank_start        (vblank_start),
    .ball_x              (ball_x),
    .ball_y              (ball_y),
    .paddle_l_y          (paddle_l_y),
    .paddle_r_y          (paddle_r_y),
    .oX                  (oX),
    .oY                  (oY),
    .oRed                (oRed),
    .oGreen              (oGreen),
    .oBlue               (oBlue),
    .write_enable        (write_enable),
    .write_buffer_select (write_buffer_select),
    .busy                (busy),
    .frame_done          (frame_done),
    .overrun             (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    return fb[y * H + x];
  endfunction

  task automatic clear_fb();
    for (int i = 0; i < NPIX; i++) fb[i] = 24'h123456;
  endtask

  // Pulse frame_start in IDLE; afterwards the DUT sits in LATCH.
  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("latch_busy", busy, 1);
    check_eq("latch_we", write_enable, 0);
    check_eq("idle_start_no_overrun", overrun, 0);
  endtask

  // Collect writes until write_enable drops. Indices (write numbers) at which
  // to inject frame_start, vblank_start, reset, or move the ball; -1 = never.
  task automatic draw_frame(input int fs_at, input int vb_at, input int rst_at, input int mv_at);
    int ex, ey;
    bit ovr_pending, ended;
    nwr = 0; order_err = 0; busy_err = 0; ovr_hits = 0;
    ex = 0; ey = 0; ovr_pending = 0; ended = 0;
    for (int i = 0; i < NPIX + 16; i++) begin
      tick();
      frame_start  = 1'b0;
      vblank_start = 1'b0;
      reset        = 1'b0;
      if (overrun) ovr_hits++;
      if (ovr_pending) begin
        check_eq("overrun_next_cycle", overrun, 1);
        ovr_pending = 0;
      end
      if (!write_enable) begin
        ended = 1;
        break;
      end
      if (!busy) busy_err++;
      if (int'(oX) != ex || int'(oY) != ey) order_err++;
      if (int'(oX) < H && int'(oY) < V) fb[int'(oY) * H + int'(oX)] = {oRed, oGreen, oBlue};
      if (nwr == fs_at) begin frame_start = 1'b1; ovr_pending = 1; end
      if (nwr == vb_at) vblank_start = 1'b1;
      if (nwr == rst_at) reset = 1'b1;
      if (nwr == mv_at) begin ball_x = 10'd5; ball_y = 10'd5; end
      nwr++;
      if (ex == H - 1) begin ex = 0; ey++; end else ex++;
    end
    check_eq("draw_terminates", {31'd0, ended}, 1);
    $display("frame: writes=%0d order_err=%0d busy_err=%0d overrun_pulses=%0d",
             nwr, order_err, busy_err, ovr_hits);
  endtask

  // From WAIT_VB: pulse vblank and check the swap handshake.
  task automatic do_swap(input logic exp_wbs);
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    check_eq("swap_wbs", write_buffer_select, exp_wbs);
    check_eq("swap_frame_done", frame_done, 1);
    check_eq("swap_busy", busy, 1);
    tick();
    check_eq("post_swap_frame_done", frame_done, 0);
    check_eq("post_swap_busy", busy, 0);
    check_eq("post_swap_wbs", write_buffer_select, exp_wbs);
  endtask

  initial begin
    int whites;
    reset = 1'b1; frame_start = 1'b0; vblank_start = 1'b0;
    ball_x = 10'd0; ball_y = 10'd0; paddle_l_y = 10'd0; paddle_r_y = 10'd0;

    // Reset state.
    repeat (3) tick();
    check_eq("rst_ctrl", {write_enable, busy, write_buffer_select, frame_done, overrun}, 0);
    check_eq("rst_xy", {oX, oY}, 0);
    check_eq("rst_rgb", {oRed, oGreen, oBlue}, 0);
    reset = 1'b0;
    tick();

    // Reset wins over frame_start in the same cycle.
    reset = 1'b1; frame_start = 1'b1;
    tick();
    reset = 1'b0; frame_start = 1'b0;
    tick();
    check_eq("rst_prio_busy", busy, 0);
    check_eq("rst_prio_we", write_enable, 0);
    $display("reset checks done");

    // Frame 1: full frame, overrun and stray vblank injected mid-draw.
    ball_x = 10'd100; ball_y = 10'd4; paddle_l_y = 10'd2; paddle_r_y = 10'd10;
    clear_fb();
    start_frame();
    draw_frame(500, 600, -1, -1);
    check_eq("f1_writes", nwr, NPIX);
    check_eq("f1_order", order_err, 0);
    check_eq("f1_busy", busy_err, 0);
    check_eq("f1_overrun_count", ovr_hits, 1);
    check_eq("f1_last_xy", {oX, oY}, {10'(H - 1), 10'(V - 1)});
    check_eq("f1_waitvb_busy", busy, 1);
    check_eq("f1_waitvb_wbs", write_buffer_select, 0);
    check_eq("px_ball_tl", pix(100, 4), 24'hFFFFFF);
    check_eq("px_ball_br", pix(107, 11), 24'hFFFFFF);
    check_eq("px_ball_right", pix(108, 4), 24'h000000);
    check_eq("px_ball_below", pix(100, 12), 24'h000000);
    check_eq("px_padl", pix(16, 2), 24'hFFFFFF);
    check_eq("px_padl_right", pix(24, 2), 24'h000000);
    check_eq("px_padl_left", pix(15, 2), 24'h000000);
    check_eq("px_padr", pix(300, 10), 24'hFFFFFF);
    check_eq("px_padr_edge", pix(307, 23), 24'hFFFFFF);
    check_eq("px_padr_left", pix(299, 10), 24'h000000);
    check_eq("px_centre", pix(319, 0), 24'h808080);
    check_eq("px_centre_r", pix(321, 15), 24'h808080);
    check_eq("px_centre_gap", pix(319, 16), 24'h000000);
    check_eq("px_centre_out", pix(322, 0), 24'h000000);
    repeat (3) tick();
    check_eq("waitvb_hold_busy", busy, 1);
    check_eq("waitvb_hold_we", write_enable, 0);
    check_eq("waitvb_hold_xy", {oX, oY}, {10'(H - 1), 10'(V - 1)});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("waitvb_overrun", overrun, 1);
    tick();
    check_eq("overrun_one_cycle", overrun, 0);
    do_swap(1'b1);

    // Frame 2: reset at write 1000 aborts the frame and clears the buffer select.
    clear_fb();
    start_frame();
    draw_frame(-1, -1, 1000, -1);
    check_eq("rst_abort_writes", nwr, 1001);
    check_eq("rst_abort_we", write_enable, 0);
    check_eq("rst_abort_wbs", write_buffer_select, 0);
    check_eq("rst_abort_busy", busy, 0);
    tick();
    check_eq("rst_abort_we_hold", write_enable, 0);
    check_eq("rst_abort_no_done", frame_done, 0);

    // Frame 3: restart from (0,0); ball over the centre line takes priority.
    ball_x = 10'd316; ball_y = 10'd0; paddle_l_y = 10'd2; paddle_r_y = 10'd10;
    clear_fb();
    start_frame();
    draw_frame(-1, -1, -1, -1);
    check_eq("f3_writes", nwr, NPIX);
    check_eq("f3_order", order_err, 0);
    check_eq("f3_first_px", pix(0, 0), 24'h000000);
    check_eq("px_ball_over_centre", pix(319, 0), 24'hFFFFFF);
    check_eq("px_ball_over_centre_edge", pix(323, 7), 24'hFFFFFF);
    check_eq("px_after_ball", pix(324, 0), 24'h000000);
    check_eq("px_centre_below_ball", pix(318, 8), 24'h808080);
    do_swap(1'b1);

    // Frame 4: objects near 1023 must clip; ball moved mid-draw is ignored.
    ball_x = 10'd1020; ball_y = 10'd1020; paddle_l_y = 10'd1000; paddle_r_y = 10'd1000;
    clear_fb();
    start_frame();
    draw_frame(-1, -1, -1, 50);
    check_eq("f4_writes", nwr, NPIX);
    check_eq("f4_order", order_err, 0);
    whites = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if ((x < 8 || y < 8) && pix(x, y) == 24'hFFFFFF) whites++;
    check_eq("no_wrap_whites", whites, 0);
    check_eq("f4_centre", pix(319, 0), 24'h808080);
    check_eq("f4_padl_clipped", pix(16, 2), 24'h000000);
    do_swap(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_frame_writer.md
PONG_FRAME_WRITER -- requirements
Module: pong_frame_writer

Interface
REQ-001 Parameters SHALL be: H_RES, 640, pixels per line; V_RES, 480, lines per frame; PAD_W, 8, paddle width; PAD_H, 64, paddle height; BALL_SZ, 8, ball edge; PAD_L_X, 16, left paddle left edge; PAD_R_X, 616, right paddle left edge.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 frame_start  in  1  one-cycle pulse requesting a new frame render.
REQ-005 vblank_start  in  1  one-cycle pulse at start of display vertical blank.
REQ-006 ball_x, ball_y  in  10 each  ball top-left corner.
REQ-007 paddle_l_y, paddle_r_y  in  10 each  paddle top edges.
REQ-008 oX, oY  out  10 each  write coordinate into frame buffer.
REQ-009 oRed, oGreen, oBlue  out  8 each  write pixel colour.
REQ-010 write_enable  out  1  pixel write strobe.
REQ-011 write_buffer_select  out  1  back buffer being written; display SHALL read the complement.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 frame_done  out  1  one-cycle pulse on buffer swap.
REQ-014 overrun  out  1  one-cycle pulse when a frame_start is dropped.

Function
REQ-015 FSM states SHALL be IDLE, LATCH, DRAW, WAIT_VB, SWAP.
REQ-016 IDLE -> LATCH on frame_start; LATCH lasts exactly 1 cycle, capturing ball_x/ball_y/paddle_l_y/paddle_r_y into internal registers, then -> DRAW.
REQ-017 DRAW SHALL emit exactly H_RES*V_RES writes, one per cycle, raster order x fastest, starting (0,0), ending (H_RES-1,V_RES-1); then -> WAIT_VB.
REQ-018 All outputs SHALL be registered; the first write (write_enable=1, oX=0, oY=0) appears the cycle after LATCH.
REQ-019 write_enable SHALL be 0 in every state other than DRAW; oX/oY/colour hold last value when write_enable=0.
REQ-020 x counter wraps H_RES-1 -> 0 with y increment; no write ever issued with oX>=H_RES or oY>=V_RES.
REQ-021 WAIT_VB -> SWAP on vblank_start; SWAP lasts 1 cycle, toggles write_buffer_select, pulses frame_done, -> IDLE.
REQ-022 vblank_start outside WAIT_VB SHALL be ignored.
REQ-023 frame_start outside IDLE SHALL be dropped and pulse overrun the following cycle; frame_start in IDLE never pulses overrun.
REQ-024 Input position changes during DRAW SHALL NOT affect the frame in progress (latched values only).
REQ-025 Colour priority: ball white (FF,FF,FF) > paddle white (FF,FF,FF) > centre line grey (80,80,80) > black (00,00,00).
REQ-026 Ball covers ball_x <= x < ball_x+BALL_SZ and ball_y <= y < ball_y+BALL_SZ; paddles cover PAD_*_X <= x < PAD_*_X+PAD_W and paddle_*_y <= y < paddle_*_y+PAD_H.
REQ-027 Range sums SHALL be computed in 11 bits so objects near 1023 clip instead of wrapping to low coordinates.
REQ-028 Centre line covers 318 <= x <= 321 where y bit 4 = 0 (16-line dashes).

Reset
REQ-029 Reset SHALL force IDLE, write_buffer_select=0, write_enable=0, busy=0, frame_done=0, overrun=0, oX=oY=0, colour=0, latched positions=0.
REQ-030 Reset asserted in any state, including mid-DRAW, SHALL abort the frame with no further writes from the next cycle; no swap occurs.
REQ-031 Reset SHALL take priority over frame_start and vblank_start in the same cycle.

Structure
REQ-032 Package pong_pkg SHALL hold the FSM state enum, H_RES/V_RES defaults and the colour constants (black, white, grey).
REQ-033 Colour selection SHALL live in one combinational sub-module pong_pixel_shader (inputs x, y, latched positions; output RGB); the FSM, counters and output registers stay in pong_frame_writer.

Verification
REQ-034 Reset, frame_start at cycle 5 -> first write (0,0) at cycle 7, exactly 307200 writes, last (639,479), busy high throughout.
REQ-035 ball=(100,200), paddles 50/300 -> pixel (100,200) white, (107,207) white, (108,200) black, (16,50) white, (24,50) black, (319,0) grey, (319,16) black.
REQ-036 ball_x=1020, ball_y=1020 -> no white pixel at x<8 or y<8 (no wrap).
REQ-037 frame_start pulsed mid-DRAW -> overrun pulse next cycle, write count unchanged; vblank_start during DRAW -> ignored; vblank_start in WAIT_VB -> write_buffer_select toggles, frame_done 1 cycle, busy falls.
REQ-038 Reset at write 1000 -> write_enable 0 next cycle, write_buffer_select 0, following frame_start restarts at (0,0).
